// File: rtl/decode_stage_if.sv
// Fetch/execute handshake bundle for decode_stage: fetch-side valid/ready,
// execute-side decoded fields, writeback notification, flush and stall count.
interface decode_stage_if #(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned OPCODE_SIZE       = 4,
  parameter int unsigned REGFILE_ADDR_BITS = 4,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned STALL_CNT_WIDTH   = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [INSTRUCTION_WIDTH-1:0] in_instr;

  logic                         out_valid;
  logic                         out_ready;
  logic [OPCODE_SIZE-1:0]       out_opcode;
  logic [REGFILE_ADDR_BITS-1:0] out_r1;
  logic [REGFILE_ADDR_BITS-1:0] out_r2;
  logic [REGFILE_ADDR_BITS-1:0] out_rd;
  logic [DATA_WIDTH-1:0]        out_imm;
  logic                         out_we;
  logic                         out_is_load;
  logic                         out_is_store;
  logic                         out_is_branch;
  logic                         out_illegal;

  logic                         wb_valid;
  logic [REGFILE_ADDR_BITS-1:0] wb_rd;
  logic                         flush;
  logic [STALL_CNT_WIDTH-1:0]   stall_cnt;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_opcode, out_r1, out_r2, out_rd, out_imm,
           out_we, out_is_load, out_is_store, out_is_branch, out_illegal,
           stall_cnt
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_opcode, out_r1, out_r2, out_rd, out_imm,
           out_we, out_is_load, out_is_store, out_is_branch, out_illegal,
           stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field split, per-class normalisation,
// immediate extension, RAW scoreboard with fetch stall, saturating stall count.
module decode_stage #(
  parameter int unsigned              INSTRUCTION_WIDTH = 32,
  parameter int unsigned              OPCODE_SIZE       = 4,
  parameter int unsigned              REGFILE_ADDR_BITS = 4,
  parameter int unsigned              IMMEDIATE_WIDTH   = 16,
  parameter int unsigned              DATA_WIDTH        = 32,
  parameter logic [OPCODE_SIZE-1:0]   OP_ADD            = 4'h1,
  parameter logic [OPCODE_SIZE-1:0]   OP_LOAD           = 4'h2,
  parameter logic [OPCODE_SIZE-1:0]   OP_STORE          = 4'h3,
  parameter logic [OPCODE_SIZE-1:0]   OP_BNE            = 4'h4,
  parameter int unsigned              STALL_CNT_WIDTH   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  localparam int unsigned NREGS  = 1 << REGFILE_ADDR_BITS;
  localparam int unsigned OP_MSB = INSTRUCTION_WIDTH - 1;
  localparam int unsigned R1_MSB = INSTRUCTION_WIDTH - OPCODE_SIZE - 1;
  localparam int unsigned R2_MSB = R1_MSB - REGFILE_ADDR_BITS;
  localparam int unsigned RD_MSB = R2_MSB - REGFILE_ADDR_BITS;

  logic [OPCODE_SIZE-1:0]       opcode;
  logic [REGFILE_ADDR_BITS-1:0] raw_r1;
  logic [REGFILE_ADDR_BITS-1:0] raw_r2;
  logic [REGFILE_ADDR_BITS-1:0] raw_rd;
  logic [IMMEDIATE_WIDTH-1:0]   raw_imm;
  logic [DATA_WIDTH-1:0]        imm_zext;
  logic [DATA_WIDTH-1:0]        imm_sext;

  assign opcode   = bus.in_instr[OP_MSB -: OPCODE_SIZE];
  assign raw_r1   = bus.in_instr[R1_MSB -: REGFILE_ADDR_BITS];
  assign raw_r2   = bus.in_instr[R2_MSB -: REGFILE_ADDR_BITS];
  assign raw_rd   = bus.in_instr[RD_MSB -: REGFILE_ADDR_BITS];
  assign raw_imm  = bus.in_instr[IMMEDIATE_WIDTH-1:0];
  assign imm_zext = DATA_WIDTH'(raw_imm);
  assign imm_sext = DATA_WIDTH'($signed(raw_imm));

  logic [REGFILE_ADDR_BITS-1:0] d_r1;
  logic [REGFILE_ADDR_BITS-1:0] d_r2;
  logic [REGFILE_ADDR_BITS-1:0] d_rd;
  logic [DATA_WIDTH-1:0]        d_imm;
  logic                         d_we;
  logic                         d_load;
  logic                         d_store;
  logic                         d_branch;
  logic                         d_illegal;
  logic                         reads_s1;
  logic                         reads_s2;
  logic                         use_sext;

  always_comb begin
    d_r1      = raw_r1;
    d_r2      = raw_r2;
    d_rd      = raw_rd;
    d_we      = 1'b0;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_branch  = 1'b0;
    d_illegal = 1'b0;
    reads_s1  = 1'b0;
    reads_s2  = 1'b0;
    use_sext  = 1'b0;
    case (opcode)
      OP_ADD: begin
        d_we     = 1'b1;
        reads_s1 = 1'b1;
        reads_s2 = 1'b1;
      end
      OP_LOAD: begin
        d_r1     = '0;
        d_rd     = raw_r2;
        d_we     = 1'b1;
        use_sext = 1'b1;
        d_load   = 1'b1;
      end
      OP_STORE: begin
        d_r1     = '0;
        d_rd     = raw_r2;
        reads_s2 = 1'b1;
        use_sext = 1'b1;
        d_store  = 1'b1;
      end
      OP_BNE: begin
        d_rd     = '0;
        reads_s1 = 1'b1;
        reads_s2 = 1'b1;
        use_sext = 1'b1;
        d_branch = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
    // Writes to r0 are dropped so r0 can never become busy.
    if (d_rd == '0) d_we = 1'b0;
    d_imm = use_sext ? imm_sext : imm_zext;
  end

  logic [NREGS-1:0] busy;
  logic             s1_busy;
  logic             s2_busy;
  logic             hazard;
  logic             accept;
  logic             issue;

  // A same-cycle writeback releases a busy source; the held, not-yet-issued
  // instruction counts as an in-flight writer.
  assign s1_busy = (busy[d_r1] && !(bus.wb_valid && bus.wb_rd == d_r1)) ||
                   (bus.out_valid && bus.out_we && bus.out_rd == d_r1);
  assign s2_busy = (busy[d_r2] && !(bus.wb_valid && bus.wb_rd == d_r2)) ||
                   (bus.out_valid && bus.out_we && bus.out_rd == d_r2);
  assign hazard  = (reads_s1 && s1_busy) || (reads_s2 && s2_busy);

  assign bus.in_ready = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign issue        = bus.out_valid && bus.out_ready && !bus.flush;

  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] set_mask;

  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (bus.wb_valid) wb_mask[bus.wb_rd] = 1'b1;
    if (issue && bus.out_we) set_mask[bus.out_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid     <= 1'b0;
      bus.out_opcode    <= '0;
      bus.out_r1        <= '0;
      bus.out_r2        <= '0;
      bus.out_rd        <= '0;
      bus.out_imm       <= '0;
      bus.out_we        <= 1'b0;
      bus.out_is_load   <= 1'b0;
      bus.out_is_store  <= 1'b0;
      bus.out_is_branch <= 1'b0;
      bus.out_illegal   <= 1'b0;
    end else if (accept) begin
      bus.out_valid     <= 1'b1;
      bus.out_opcode    <= opcode;
      bus.out_r1        <= d_r1;
      bus.out_r2        <= d_r2;
      bus.out_rd        <= d_rd;
      bus.out_imm       <= d_imm;
      bus.out_we        <= d_we;
      bus.out_is_load   <= d_load;
      bus.out_is_store  <= d_store;
      bus.out_is_branch <= d_branch;
      bus.out_illegal   <= d_illegal;
    end else if (bus.flush || bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Set from issue is OR-ed after the writeback clear so the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= {(busy[NREGS-1:1] & ~wb_mask[NREGS-1:1]) | set_mask[NREGS-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stall_cnt <= '0;
    end else if (bus.in_valid && hazard && (bus.stall_cnt != '1)) begin
      bus.stall_cnt <= bus.stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parameterised instruction-decode pipeline stage between fetch and execute.
- Splits the instruction into fields, normalises register fields per instruction class, and extends the immediate.
- Tracks in-flight register writes in a scoreboard and stalls fetch on read-after-write hazards.
- Uses valid/ready handshakes on both sides, one output register, a flush input, and a saturating stall counter.

Parameters:
INSTRUCTION_WIDTH, 32, instruction width in bits.
OPCODE_SIZE, 4, opcode width; the opcode is the top OPCODE_SIZE bits.
REGFILE_ADDR_BITS, 4, width of each register field; the register file has 2**REGFILE_ADDR_BITS entries.
IMMEDIATE_WIDTH, 16, raw immediate width; the immediate is the low bits of the instruction.
DATA_WIDTH, 32, width of the extended immediate; must be >= IMMEDIATE_WIDTH.
OP_ADD, 4'h1, opcode of ADD.
OP_LOAD, 4'h2, opcode of LW.
OP_STORE, 4'h3, opcode of SW.
OP_BNE, 4'h4, opcode of BNE.
STALL_CNT_WIDTH, 16, width of the stall counter.

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  INSTRUCTION_WIDTH  instruction word
out_valid  out  1  decoded instruction held for execute
out_ready  in  1  execute takes the held instruction
out_opcode  out  OPCODE_SIZE  opcode
out_r1  out  REGFILE_ADDR_BITS  source register 1
out_r2  out  REGFILE_ADDR_BITS  source register 2
out_rd  out  REGFILE_ADDR_BITS  destination register
out_imm  out  DATA_WIDTH  extended immediate
out_we  out  1  instruction writes out_rd
out_is_load, out_is_store, out_is_branch, out_illegal  out  1 each  class flags
wb_valid  in  1  writeback completes this cycle
wb_rd  in  REGFILE_ADDR_BITS  register being written back
flush  in  1  discard the held instruction (branch taken)
stall_cnt  out  STALL_CNT_WIDTH  count of hazard-stall cycles, saturating

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0; all scoreboard bits=0; stall_cnt=0; all out_* data outputs=0.
- Field slicing, MSB downward: opcode, raw_R1, raw_R2, raw_Rd, then a gap; raw_imm is the low IMMEDIATE_WIDTH bits.
- Per-class mapping (r1, r2, rd, we, sources read, immediate):
  - ADD: (raw_R1, raw_R2, raw_Rd, 1, reads r1 and r2, zero-extended).
  - LOAD: (0, raw_R2, raw_R2, 1, reads none, sign-extended).
  - STORE: (0, raw_R2, raw_R2, 0, reads r2, sign-extended).
  - BNE: (raw_R1, raw_R2, 0, 0, reads r1 and r2, sign-extended).
  - Any other opcode: raw fields pass through, we=0, reads none, zero-extended, out_illegal=1.
- we is forced to 0 when rd==0. Register 0 is never busy.
- Hazard: a read source s is busy if any of these holds:
  - busy[s]=1 and not (wb_valid and wb_rd==s); same-cycle writeback clears the hazard.
  - out_valid=1, out_we=1 and out_rd==s; the held instruction has not issued yet.
- in_ready = !flush and !hazard and (!out_valid or out_ready). This is combinational from in_instr; in_ready does not depend on in_valid.
- Accept (in_valid and in_ready): the output registers load the decode result; out_valid=1 on the next cycle. Latency is 1 cycle.
- If out_valid and out_ready and no accept: out_valid=0.
- Issue (out_valid and out_ready and !flush): if out_we, busy[out_rd] is set.
- wb_valid clears busy[wb_rd]. If the same register is set by issue and cleared by writeback in the same cycle, the set wins.
- flush: out_valid=0 the next cycle; the held instruction does not issue; no accept that cycle; existing scoreboard bits are kept.
- stall_cnt increments each cycle in_valid=1 and hazard=1; it holds at all-ones.
- Back-pressure: with out_valid=1 and out_ready=0, all out_* hold stable.

Test Plan:
- After reset, ADD r1=2,r2=3,rd=5 accepted with out_ready=1 -> next cycle out_valid=1, out_rd=5, out_we=1; busy[5] set on issue.
- LOAD raw_R2=7, imm=16'hFFFC -> out_r1=0, out_rd=7, out_imm=32'hFFFF_FFFC, out_is_load=1.
- Issued ADD rd=5, then BNE r1=5 presented -> in_ready=0 and stall_cnt increments each cycle; wb_valid with wb_rd=5 -> in_ready=1 in that same cycle.
- ADD rd=4 held with out_ready=0, then ADD r1=4 presented -> in_ready=0 and outputs held stable; out_ready=1 -> next instruction stalls until wb_rd=4.
- flush while ADD rd=6 is held -> out_valid=0 next cycle, busy[6] stays 0, in_ready=0 during the flush cycle.
- Opcode 4'hF -> out_illegal=1, out_we=0, no stall; ADD with rd=0 -> out_we=0. Assert rst_n mid-stall -> all outputs and busy bits clear immediately.
